blink_scheduler: RTL and testbench

//  Shares one LED blinker between NREQ requesters (status sources).
//  - A CBITS-wide free-running prescaler generates a 1-cycle tick.
//  - A round-robin arbiter grants the LED to one requester at a time.
//  - A pattern FSM drives led with the winner's pattern (off/solid/blink/burst).

---
 rtl/blink_scheduler.sv | 160 ++++++++++++++++
 tb/tb_blink_scheduler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/blink_scheduler.sv
// Shares one LED blinker between NREQ requesters: prescaler tick, round-robin owner, pattern FSM.
// Optional build macro BLINK_PREEMPT_EN makes req[0] urgent and able to take the LED from any other owner.
module blink_scheduler #(
    parameter int CBITS     = 29,
    parameter int NREQ      = 4,
    parameter int BURST_LEN = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] pat,
    output logic [NREQ-1:0]   grant,
    output logic              led,
    output logic              tick,
    output logic              busy
);

    localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int PCW = $clog2(BURST_LEN + 1);
    localparam logic [PCW-1:0] PC_LAST  = PCW'(BURST_LEN);
    localparam logic [PCW-1:0] GAP_LAST = PCW'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        SOLID,
        BLINK,
        BURST_ON,
        BURST_OFF,
        GAP
    } state_t;

    function automatic state_t entry_state(input logic [1:0] p);
        case (p)
            2'b01:   return SOLID;
            2'b10:   return BLINK;
            2'b11:   return BURST_ON;
            default: return IDLE;
        endcase
    endfunction

    logic [CBITS-1:0] cnt;
    logic             tick_en;
    state_t           state, state_d;
    logic [NREQ-1:0]  grant_d;
    logic [PW-1:0]    rr_ptr, rr_d;
    logic [PCW-1:0]   pcnt, pcnt_d;
    logic             led_d;
    logic             keep;
    logic             preempt;
    logic             restart;

    // The update edge is the one that raises tick, so grant/led change in the tick cycle.
    assign tick_en = (cnt == '0);
    assign busy    = |grant;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= tick_en;
        end
    end

    // State register: owner, pointer, pattern state and LED only move on tick edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= '0;
            pcnt   <= '0;
            led    <= 1'b0;
        end else if (tick_en) begin
            state  <= state_d;
            grant  <= grant_d;
            rr_ptr <= rr_d;
            pcnt   <= pcnt_d;
            led    <= led_d;
        end
    end

    // Next-state: keep/advance the current owner, otherwise hand over round-robin.
    always_comb begin
        int  win;
        bit  found;
        int  idx;
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d = state;
        grant_d = grant;
        rr_d    = rr_ptr;
        pcnt_d  = pcnt;
        win     = 0;
        found   = 1'b0;
        keep    = |(grant & req);
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(rr_ptr) + i) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
`ifdef BLINK_PREEMPT_EN
        preempt = req[0] && keep && !grant[0];
`else
        preempt = 1'b0;
`endif
        if (preempt) begin
            grant_d = NREQ'(1);
            state_d = entry_state(pat[1:0]);
            pcnt_d  = '0;
        end else if (keep) begin
            case (state)
                BURST_ON: begin
                    state_d = BURST_OFF;
                    pcnt_d  = pcnt + 1'b1;
                end
                BURST_OFF: begin
                    if (pcnt == PC_LAST) begin
                        state_d = GAP;
                        pcnt_d  = '0;
                    end else begin
                        state_d = BURST_ON;
                    end
                end
                GAP: begin
                    if (pcnt == GAP_LAST) begin
                        state_d = BURST_ON;
                        pcnt_d  = '0;
                    end else begin
                        pcnt_d = pcnt + 1'b1;
                    end
                end
                default: state_d = state;
            endcase
        end else if (found) begin
            grant_d = NREQ'(1) << win;
            rr_d    = PW'((win + 1) % NREQ);
            state_d = entry_state(pat[2*win +: 2]);
            pcnt_d  = '0;
        end else begin
            grant_d = '0;
            state_d = IDLE;
            pcnt_d  = '0;
        end
    end

    // Output decode: a fresh grant always starts the pattern in its "on" phase.
    always_comb begin
        restart = preempt || !keep;
        case (state_d)
            SOLID:    led_d = 1'b1;
            BLINK:    led_d = restart ? 1'b1 : ~led;
            BURST_ON: led_d = 1'b1;
            default:  led_d = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_blink_scheduler.sv
// Self-checking bench for blink_scheduler (CBITS=3, NREQ=4, BURST_LEN=3), scoreboard of per-tick grant/led.
module tb_blink_scheduler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [7:0] pat = '0;
    logic [3:0] grant;
    logic       led;
    logic       tick;
    logic       busy;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0] grant;
        logic       led;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    blink_scheduler #(
        .CBITS(3),
        .NREQ(4),
        .BURST_LEN(3)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req(req),
        .pat(pat),
        .grant(grant),
        .led(led),
        .tick(tick),
        .busy(busy)
    );

    task automatic push(input logic [3:0] g, input logic l);
        exp_t e;
        e.grant = g;
        e.led   = l;
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input logic [3:0] r, input logic [7:0] p);
        @(negedge clk);
        rst_n = 1'b0;
        req   = r;
        pat   = p;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Returns the number of negedges until tick is seen high; 0 means it never came.
    task automatic next_tick(output int cyc);
        cyc = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (tick === 1'b1) begin
                cyc = i;
                break;
            end
        end
        checks++;
        if (cyc == 0) begin
            errors++;
            $display("FAIL tick_timeout got no tick, required one within 16 cycles");
        end
    endtask

    task automatic check_tick(input string name, output int cyc);
        exp_t e;
        next_tick(cyc);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty", name);
            return;
        end
        e = exp_q.pop_front();
        if (grant !== e.grant || led !== e.led || busy !== (|e.grant)) begin
            errors++;
            $display("FAIL %s got grant=%b led=%b busy=%b required grant=%b led=%b busy=%b",
                     name, grant, led, busy, e.grant, e.led, |e.grant);
        end
    endtask

    task automatic test_reset();
        int cyc;
        rst_n = 1'b0;
        req   = '0;
        pat   = '0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (tick !== 1'b0 || led !== 1'b0 || grant !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got tick=%b led=%b grant=%b busy=%b required all zero",
                     tick, led, grant, busy);
        end
        rst_n = 1'b1;
        next_tick(cyc);
        checks++;
        if (cyc != 1) begin
            errors++;
            $display("FAIL first_tick got cycle %0d required 1", cyc);
        end
        for (int k = 0; k < 2; k++) begin
            next_tick(cyc);
            checks++;
            if (cyc != 8) begin
                errors++;
                $display("FAIL tick_period got %0d required 8", cyc);
            end
            checks++;
            if (led !== 1'b0 || grant !== 4'b0000) begin
                errors++;
                $display("FAIL idle_outputs got led=%b grant=%b required 0 0000", led, grant);
            end
        end
    endtask

    task automatic test_blink();
        int cyc;
        do_reset(4'b0001, 8'b00_00_00_10);
        push(4'b0001, 1'b1);
        push(4'b0001, 1'b0);
        push(4'b0001, 1'b1);
        push(4'b0001, 1'b0);
        for (int k = 0; k < 4; k++) check_tick("blink", cyc);
        req = 4'b0000;
        push(4'b0000, 1'b0);
        check_tick("blink_release", cyc);
    endtask

    task automatic test_back_to_back();
        int cyc;
        do_reset(4'b0101, 8'b00_10_00_01);
        push(4'b0001, 1'b1);
        check_tick("handover_first", cyc);
        req = 4'b0100;
        push(4'b0100, 1'b1);
        push(4'b0100, 1'b0);
        check_tick("handover_same_tick", cyc);
        check_tick("handover_blink", cyc);
    endtask

    task automatic test_round_robin();
        int cyc;
        do_reset(4'b1001, 8'b00_00_00_01);
        push(4'b0001, 1'b1);
        check_tick("rr_first", cyc);
        req = 4'b1000;
        push(4'b1000, 1'b0);
        check_tick("rr_pat_off_held", cyc);
        req = 4'b1001;
        push(4'b1000, 1'b0);
        check_tick("rr_no_preempt", cyc);
        req = 4'b0001;
        push(4'b0001, 1'b1);
        check_tick("rr_wrap", cyc);
    endtask

    task automatic test_burst();
        int cyc;
        logic [10:0] seq;
        seq = 11'b1_0101_0000_10;
        do_reset(4'b0010, 8'b00_00_11_00);
        for (int k = 10; k >= 0; k--) push(4'b0010, seq[k]);
        for (int k = 0; k < 11; k++) check_tick("burst", cyc);
    endtask

    task automatic test_pat_latch();
        int cyc;
        do_reset(4'b0001, 8'b00_00_00_01);
        push(4'b0001, 1'b1);
        check_tick("latch_entry", cyc);
        pat = 8'b00_00_00_10;
        for (int k = 0; k < 3; k++) push(4'b0001, 1'b1);
        for (int k = 0; k < 3; k++) check_tick("latch_ignore", cyc);
    endtask

    task automatic test_reset_mid();
        int cyc;
        do_reset(4'b0010, 8'b00_00_11_00);
        push(4'b0010, 1'b1);
        push(4'b0010, 1'b0);
        push(4'b0010, 1'b1);
        for (int k = 0; k < 3; k++) check_tick("mid_burst", cyc);
        rst_n = 1'b0;
        #1;
        checks++;
        if (tick !== 1'b0 || led !== 1'b0 || grant !== 4'b0000 || busy !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got tick=%b led=%b grant=%b busy=%b required all zero",
                     tick, led, grant, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        push(4'b0010, 1'b1);
        check_tick("restart", cyc);
        checks++;
        if (cyc != 1) begin
            errors++;
            $display("FAIL restart_tick got cycle %0d required 1", cyc);
        end
    endtask

    initial begin
        test_reset();
        test_blink();
        test_back_to_back();
        test_round_robin();
        test_burst();
        test_pat_latch();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
